// File: rtl/l2_mem_responder_pkg.sv
// rtl/l2_mem_responder_pkg.sv - shared L2 memory line types and states
package l2_mem_responder_pkg;

   localparam int LINE_W = 128;
   localparam int ADDR_W = 28;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } mem_state_e;

endpackage

// File: rtl/l2_mem_array.sv
// rtl/l2_mem_array.sv - line storage, synchronous write, combinational read, no reset
module l2_mem_array
   import l2_mem_responder_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clk,
   input  logic                  we_i,
   input  logic [DEPTH_LOG2-1:0] waddr_i,
   input  logic [LINE_W-1:0]     wdata_i,
   input  logic [DEPTH_LOG2-1:0] raddr_i,
   output logic [LINE_W-1:0]     rdata_o
);

   logic [LINE_W-1:0] mem_q [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/l2_mem_responder.sv
// rtl/l2_mem_responder.sv - fixed-latency L2 backing memory model with counters
module l2_mem_responder
   import l2_mem_responder_pkg::*;
#(
   parameter int LATENCY    = 8,
   parameter int DEPTH_LOG2 = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [LINE_W-1:0] mem_wdata,
   output logic              mem_ready,
   output logic [LINE_W-1:0] mem_rdata,
   output logic [15:0]       rd_cnt,
   output logic [15:0]       wr_cnt,
   output logic              proto_err
);

   localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

   mem_state_e            state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  is_wr_q, is_wr_d;
   logic [DEPTH_LOG2-1:0] idx_q, idx_d;
   logic [15:0]           rd_cnt_q, rd_cnt_d;
   logic [15:0]           wr_cnt_q, wr_cnt_d;
   logic                  err_q, err_d;
   logic                  arr_we;
   logic [LINE_W-1:0]     arr_rdata;
   logic                  unused_addr_hi;

   assign unused_addr_hi = ^mem_addr[ADDR_W-1:DEPTH_LOG2];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         is_wr_q  <= 1'b0;
         idx_q    <= '0;
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         is_wr_q  <= is_wr_d;
         idx_q    <= idx_d;
         rd_cnt_q <= rd_cnt_d;
         wr_cnt_q <= wr_cnt_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      is_wr_d  = is_wr_q;
      idx_d    = idx_q;
      rd_cnt_d = rd_cnt_q;
      wr_cnt_d = wr_cnt_q;
      err_d    = err_q;
      arr_we   = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               is_wr_d = mem_write;
               cnt_d   = LAT_M1;
               state_d = BUSY;
               if (mem_read && mem_write) begin
                  err_d = 1'b1;
               end
            end
         end
         BUSY: begin
            // A request dropped mid-flight is abandoned with no side effects.
            if (!(mem_read || mem_write)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == 8'd1) begin
               state_d = RESP;
               cnt_d   = '0;
               idx_d   = mem_addr[DEPTH_LOG2-1:0];
               if (is_wr_q) begin
                  arr_we = 1'b1;
                  if (wr_cnt_q != 16'hFFFF) wr_cnt_d = wr_cnt_q + 16'd1;
               end else begin
                  if (rd_cnt_q != 16'hFFFF) rd_cnt_d = rd_cnt_q + 16'd1;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   l2_mem_array #(
      .DEPTH_LOG2(DEPTH_LOG2)
   ) u_array (
      .clk     (clk),
      .we_i    (arr_we),
      .waddr_i (mem_addr[DEPTH_LOG2-1:0]),
      .wdata_i (mem_wdata),
      .raddr_i (idx_q),
      .rdata_o (arr_rdata)
   );

   assign mem_ready = (state_q == RESP);
   assign mem_rdata = (state_q == RESP && !is_wr_q) ? arr_rdata : '0;
   assign rd_cnt    = rd_cnt_q;
   assign wr_cnt    = wr_cnt_q;
   assign proto_err = err_q;

endmodule

// File: tb/tb_l2_mem_responder.sv
// tb/tb_l2_mem_responder.sv - directed self-checking bench for l2_mem_responder
module tb_l2_mem_responder;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic         mem_ready;
   logic [127:0] mem_rdata;
   logic [15:0]  rd_cnt;
   logic [15:0]  wr_cnt;
   logic         proto_err;

   int checks = 0;
   int errors = 0;

   localparam logic [127:0] PAT_A5 = {16{8'hA5}};
   localparam logic [127:0] ZERO   = '0;

   always #5 clk = ~clk;

   l2_mem_responder #(.LATENCY(4), .DEPTH_LOG2(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_ready (mem_ready),
      .mem_rdata (mem_rdata),
      .rd_cnt    (rd_cnt),
      .wr_cnt    (wr_cnt),
      .proto_err (proto_err)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at the mem_ready negedge.
   task automatic xact(input logic wr, input logic rd, input logic [27:0] addr,
                       input logic [127:0] wd0, input logic [127:0] wd, input bit hold,
                       output int lat, output logic [127:0] rdat);
      mem_write = wr;
      mem_read  = rd;
      mem_addr  = addr;
      mem_wdata = wd0;
      @(posedge clk);
      #1 mem_wdata = wd;
      lat  = 0;
      rdat = '0;
      while (lat < 300) begin
         @(negedge clk);
         lat++;
         if (mem_ready) begin
            rdat = mem_rdata;
            break;
         end
         check("rdata_not_ready", mem_rdata, ZERO);
      end
      if (!hold) begin
         mem_write = 1'b0;
         mem_read  = 1'b0;
      end
   endtask

   initial begin
      int           lat;
      int           gap;
      logic [127:0] rd;
      bit           seen;

      reset_n   = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 128'(mem_ready), 128'(0));
      check("rst_rdata", mem_rdata, ZERO);
      check("rst_rd_cnt", 128'(rd_cnt), 128'(0));
      check("rst_wr_cnt", 128'(wr_cnt), 128'(0));
      check("rst_proto_err", 128'(proto_err), 128'(0));
      reset_n = 1'b1;
      @(negedge clk);

      // Basic write then read of line 5
      xact(1'b1, 1'b0, 28'h5, PAT_A5, PAT_A5, 1'b0, lat, rd);
      check("wr_latency", 128'(lat), 128'(4));
      check("wr_rdata_zero", rd, ZERO);
      check("wr_cnt_1", 128'(wr_cnt), 128'(1));
      @(negedge clk);
      xact(1'b0, 1'b1, 28'h5, ZERO, ZERO, 1'b0, lat, rd);
      check("rd_latency", 128'(lat), 128'(4));
      check("rd_data", rd, PAT_A5);
      check("rd_cnt_1", 128'(rd_cnt), 128'(1));
      @(negedge clk);
      check("rd_after_zero", mem_rdata, ZERO);

      // Write data valid only after the request edge
      xact(1'b1, 1'b0, 28'h7, ZERO, 128'h1234, 1'b0, lat, rd);
      @(negedge clk);
      xact(1'b0, 1'b1, 28'h7, ZERO, ZERO, 1'b0, lat, rd);
      check("late_wdata", rd, 128'h1234);
      @(negedge clk);
      xact(1'b0, 1'b1, 28'h15, ZERO, ZERO, 1'b0, lat, rd);
      check("alias_rd", rd, PAT_A5);
      @(negedge clk);

      // Write held through RESP, read in the next cycle
      xact(1'b1, 1'b0, 28'h9, 128'hBEEF, 128'hBEEF, 1'b1, lat, rd);
      gap = 1;
      @(negedge clk);
      check("stale_no_ready", 128'(mem_ready), 128'(0));
      mem_write = 1'b0;
      mem_read  = 1'b1;
      while (gap < 300) begin
         @(negedge clk);
         gap++;
         if (mem_ready) break;
      end
      check("b2b_gap", 128'(gap), 128'(5));
      check("b2b_rdata", mem_rdata, 128'hBEEF);
      mem_read = 1'b0;
      check("b2b_wr_cnt", 128'(wr_cnt), 128'(3));
      check("b2b_rd_cnt", 128'(rd_cnt), 128'(4));
      @(negedge clk);

      // Abort: request dropped in BUSY
      mem_read = 1'b1;
      mem_addr = 28'h5;
      @(negedge clk);
      mem_read = 1'b0;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (mem_ready) seen = 1'b1;
      end
      check("abort_no_ready", 128'(seen), 128'(0));
      check("abort_rd_cnt", 128'(rd_cnt), 128'(4));

      // Kind change during BUSY is ignored
      mem_write = 1'b1;
      mem_addr  = 28'hC;
      mem_wdata = 128'hE0E0;
      @(posedge clk);
      #1 begin
         mem_write = 1'b0;
         mem_read  = 1'b1;
      end
      gap = 0;
      while (gap < 300) begin
         @(negedge clk);
         gap++;
         if (mem_ready) break;
      end
      check("kind_lat", 128'(gap), 128'(4));
      check("kind_rdata_zero", mem_rdata, ZERO);
      mem_read = 1'b0;
      check("kind_wr_cnt", 128'(wr_cnt), 128'(4));
      check("kind_rd_cnt", 128'(rd_cnt), 128'(4));
      @(negedge clk);
      xact(1'b0, 1'b1, 28'hC, ZERO, ZERO, 1'b0, lat, rd);
      check("kind_readback", rd, 128'hE0E0);
      @(negedge clk);

      // Reset two cycles into BUSY
      mem_write = 1'b1;
      mem_addr  = 28'h3;
      mem_wdata = 128'h33;
      @(posedge clk);
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("mid_rst_ready", 128'(mem_ready), 128'(0));
      check("mid_rst_rd_cnt", 128'(rd_cnt), 128'(0));
      check("mid_rst_wr_cnt", 128'(wr_cnt), 128'(0));
      mem_write = 1'b0;
      seen = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (mem_ready) seen = 1'b1;
      end
      check("mid_rst_no_ready", 128'(seen), 128'(0));
      reset_n = 1'b1;
      @(negedge clk);
      xact(1'b0, 1'b1, 28'h5, ZERO, ZERO, 1'b0, lat, rd);
      check("post_rst_lat", 128'(lat), 128'(4));
      check("post_rst_data", rd, PAT_A5);
      check("post_rst_rd_cnt", 128'(rd_cnt), 128'(1));
      @(negedge clk);

      // Both kinds at once: protocol error, serviced as write
      xact(1'b1, 1'b1, 28'hB, 128'hD, 128'hD, 1'b0, lat, rd);
      check("both_lat", 128'(lat), 128'(4));
      check("both_rdata_zero", rd, ZERO);
      check("both_proto_err", 128'(proto_err), 128'(1));
      check("both_wr_cnt", 128'(wr_cnt), 128'(1));
      check("both_rd_cnt", 128'(rd_cnt), 128'(1));
      @(negedge clk);
      xact(1'b0, 1'b1, 28'hB, ZERO, ZERO, 1'b0, lat, rd);
      check("both_readback", rd, 128'hD);
      check("err_sticky", 128'(proto_err), 128'(1));
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/l2_mem_responder.md
L2_MEM_RESPONDER -- requirements
Module: l2_mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 8: request-sample edge to mem_ready cycle, in cycles; legal range 2..255.
REQ-002 SHALL have parameter DEPTH_LOG2, default 10: array holds 2**DEPTH_LOG2 lines of 128 bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port mem_read, input, 1 bit: line read request, held high until mem_ready is seen.
REQ-006 SHALL have port mem_write, input, 1 bit: line write request, held high until mem_ready is seen.
REQ-007 SHALL have port mem_addr, input, 28 bits: line address.
REQ-008 SHALL have port mem_wdata, input, 128 bits: write line data.
REQ-009 SHALL have port mem_ready, output, 1 bit: single-cycle completion pulse.
REQ-010 SHALL have port mem_rdata, output, 128 bits: read line, valid only while mem_ready=1.
REQ-011 SHALL have port rd_cnt, output, 16 bits: completed reads, saturating.
REQ-012 SHALL have port wr_cnt, output, 16 bits: completed writes, saturating.
REQ-013 SHALL have port proto_err, output, 1 bit: sticky protocol-error flag.

Function
REQ-014 SHALL implement states IDLE, BUSY, RESP.
REQ-015 IDLE: a rising edge with mem_read|mem_write high SHALL latch the kind (write if mem_write), load the counter to LATENCY-1 and enter BUSY.
REQ-016 BUSY: each edge SHALL decrement the counter; the edge at counter 1 SHALL enter RESP, so mem_ready is high exactly LATENCY cycles after the sampling edge.
REQ-017 SHALL use only the low DEPTH_LOG2 bits of mem_addr as the array index; upper bits alias.
REQ-018 Address and write data SHALL be sampled on the BUSY->RESP edge, not the request edge; wdata may be invalid on the first request cycle.
REQ-019 Write: the array line SHALL be updated on the BUSY->RESP edge; wr_cnt increments on that edge.
REQ-020 Read: mem_rdata SHALL carry array[index] during RESP; rd_cnt increments on the BUSY->RESP edge.
REQ-021 mem_rdata SHALL be 0 in every cycle where mem_ready=0, and during a write RESP.
REQ-022 RESP SHALL last one cycle, then go to IDLE unconditionally; the request still high in the RESP cycle is stale and SHALL NOT start a transaction.
REQ-023 A fresh request in the cycle after RESP SHALL be sampled in IDLE as in REQ-015 (back-to-back writeback then read).
REQ-024 If both mem_read and mem_write drop in BUSY, SHALL abort to IDLE: no array update, no mem_ready, no counter change.
REQ-025 mem_read and mem_write both high in IDLE SHALL set proto_err and service the request as a write.
REQ-026 A request-kind change during BUSY SHALL be ignored; the latched kind completes.
REQ-027 rd_cnt and wr_cnt SHALL hold at 16'hFFFF once reached.

Reset
REQ-028 Asserting reset_n low SHALL immediately force IDLE, mem_ready=0, mem_rdata=0, rd_cnt=0, wr_cnt=0, proto_err=0 and clear the counter, including mid-transaction.
REQ-029 Array contents SHALL NOT be reset; reads of never-written lines are undefined.
REQ-030 The first request sampled after reset_n rises SHALL follow REQ-015 timing.

Structure
REQ-031 A shared package SHALL hold the state enum, LINE_W=128 and ADDR_W=28, also used by the L2 cache.
REQ-032 Storage SHALL be one sub-module, l2_mem_array: synchronous write, combinational read, no reset.

Verification
REQ-033 LATENCY=4: write addr 28'h5, wdata 128'hA5..A5 -> mem_ready exactly 4 cycles after the sampling edge; wr_cnt=1.
REQ-034 Read addr 28'h5 after REQ-033 -> mem_rdata=128'hA5..A5 in the single mem_ready cycle, 0 before and after; rd_cnt=1.
REQ-035 Write with wdata=0 on the first request cycle, 128'h1234 afterwards -> stored line reads back 128'h1234.
REQ-036 Write held high through RESP, then a read in the next cycle -> exactly one write completes, then one read; mem_ready pulses twice, LATENCY+1 cycles apart.
REQ-037 reset_n low 2 cycles into BUSY -> no mem_ready pulse, counters 0; next request completes in LATENCY cycles.
REQ-038 mem_read=mem_write=1 in IDLE -> proto_err=1 and stays set; wr_cnt increments; rd_cnt unchanged.
